// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN (port 0 always wins conflicts).
package dmem_arb_pkg;

  localparam int unsigned AW_DEF    = 6;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned NUM_PORTS = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Index of the asserted bit of a 2-bit one-hot select.
  function automatic logic onehot_idx(input logic [NUM_PORTS-1:0] sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: returns a one-hot select among eligible requesters.
// On conflict the requester named by ptr wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] elig,
  input  logic                 ptr,
  output logic [NUM_PORTS-1:0] sel_c
);

  always_comb begin
    sel_c = '0;
    case (elig)
      2'b01:   sel_c = 2'b01;
      2'b10:   sel_c = 2'b10;
      2'b11:   sel_c[ptr] = 1'b1;
      default: sel_c = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and DMA/debug (port 1) accesses onto a single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  state_t               state;
  logic                 cmd_port;
  logic                 arb_ptr;
  logic [NUM_PORTS-1:0] elig_c;
  logic [NUM_PORTS-1:0] sel_c;

  // A request seen while its own grant is high is the one being served.
  assign elig_c = {req1 & ~gnt1, req0 & ~gnt0};

  rr_arb2 u_arb (
    .elig  (elig_c),
    .ptr   (arb_ptr),
    .sel_c (sel_c)
  );

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign arb_ptr = PORT0;
`else
  logic rr_ptr;

  // Pointer moves to the port that was not just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PORT0;
    end else if (|sel_c) begin
      rr_ptr <= ~onehot_idx(sel_c);
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_port <= PORT0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
    end else begin
      gnt0    <= sel_c[0];
      gnt1    <= sel_c[1];
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      // Read return for the command that was on the memory this cycle.
      if (state == ISSUE && !mem_we) begin
        if (cmd_port == PORT1) begin
          rvalid1 <= 1'b1;
          rdata1  <= mem_q;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= mem_q;
        end
      end

      if (|sel_c) begin
        state    <= ISSUE;
        cmd_port <= onehot_idx(sel_c);
        if (sel_c[1]) begin
          mem_we <= we1;
          mem_a  <= addr1;
          mem_d  <= wdata1;
        end else begin
          mem_we <= we0;
          mem_a  <= addr0;
          mem_d  <= wdata0;
        end
      end else begin
        // mem_a/mem_d hold so the memory address bus stays quiet.
        state  <= IDLE;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, reset-in-flight
// sequence, and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_d, mem_q;
  logic [AW-1:0] mem_a;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ram [DEPTH];

  always #5 clk = ~clk;

  // Existing data memory: combinational read, write on clock edge.
  assign mem_q = ram[mem_a];
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  typedef struct {
    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, v0, v1, mwe;
    logic [DW-1:0] q0, q1;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic g0, input logic g1, input logic v0, input logic v1,
      input logic [DW-1:0] q0, input logic [DW-1:0] q1,
      input logic mwe, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.q0 = q0; v.q1 = q1; v.mwe = mwe; v.ma = ma; v.md = md;
    return v;
  endfunction

  function automatic vec_t idle_v(input logic v0, input logic v1, input logic [DW-1:0] q0,
                                  input logic [DW-1:0] q1);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, v0, v1, q0, q1, 0, 0, 0);
  endfunction

  // Reference model state, expressed as transaction rules rather than hardware.
  logic [DW-1:0] mmem [DEPTH];
  logic [1:0]    m_prev_gnt;
  int            m_last_winner;   // -1 when nobody granted yet since reset
  int            m_inflight;      // port of the op on the memory, -1 when none
  logic          m_if_we;
  logic [AW-1:0] m_if_a;
  logic [DW-1:0] m_if_d;
  logic [DW-1:0] m_rdata [2];
  logic [AW-1:0] m_mem_a;

  task automatic model_reset();
    m_prev_gnt    = 2'b00;
    m_last_winner = -1;
    m_inflight    = -1;
    m_if_we       = 1'b0;
    m_if_a        = '0;
    m_if_d        = '0;
    m_rdata[0]    = '0;
    m_rdata[1]    = '0;
    m_mem_a       = '0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = ram[i];
  endtask

  // Advance the model by one clock edge using the inputs currently driven, then compare.
  task automatic model_edge_and_check();
    logic [1:0]    elig;
    logic [1:0]    exp_v;
    int            win;
    logic          req [2];
    logic          we  [2];
    logic [AW-1:0] ad  [2];
    logic [DW-1:0] wd  [2];
    req[0] = req0; req[1] = req1; we[0] = we0; we[1] = we1;
    ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1;
    exp_v = 2'b00;

    if (m_inflight >= 0) begin
      if (m_if_we) mmem[m_if_a] = m_if_d;
      else begin
        exp_v[m_inflight]    = 1'b1;
        m_rdata[m_inflight]  = mmem[m_if_a];
      end
    end

    for (int p = 0; p < 2; p++) elig[p] = req[p] && !m_prev_gnt[p];
    win = -1;
    if (elig == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = (m_last_winner == 0) ? 1 : 0;
`endif
    end else if (elig[0]) win = 0;
    else if (elig[1]) win = 1;

    m_prev_gnt = 2'b00;
    m_inflight = win;
    if (win >= 0) begin
      m_prev_gnt[win] = 1'b1;
      m_last_winner   = win;
      m_if_we         = we[win];
      m_if_a          = ad[win];
      m_if_d          = wd[win];
      m_mem_a         = ad[win];
    end

    @(posedge clk);
    #1;
    chk("rnd_gnt0",    64'(gnt0),    64'(m_prev_gnt[0]));
    chk("rnd_gnt1",    64'(gnt1),    64'(m_prev_gnt[1]));
    chk("rnd_rvalid0", 64'(rvalid0), 64'(exp_v[0]));
    chk("rnd_rvalid1", 64'(rvalid1), 64'(exp_v[1]));
    chk("rnd_rdata0",  64'(rdata0),  64'(m_rdata[0]));
    chk("rnd_rdata1",  64'(rdata1),  64'(m_rdata[1]));
    chk("rnd_mem_we",  64'(mem_we),  64'((win >= 0) && m_if_we));
    chk("rnd_mem_a",   64'(mem_a),   64'(m_mem_a));
    if (win >= 0) chk("rnd_mem_d", 64'(mem_d), 64'(m_if_d));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'hFFFF_FFFF;

    // Directed table; one entry per clock edge starting right after reset release.
    tbl.push_back(idle_v(0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF));
    tbl.push_back(idle_v(0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0));
    tbl.push_back(idle_v(0, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(idle_v(0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 32'hA5A5_0001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'hA5A5_0001));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle_v(0, 1, 0, 32'hA5A5_0001));
    for (int k = 0; k < 6; k++) begin
      logic v0, v1;
      v0 = (k % 2 == 1);
      v1 = (k >= 2) && (k % 2 == 0);
      tbl.push_back(mk(1, 0, 5, 0, 1, 0, 1, 0, k % 2 == 0, k % 2 == 1, v0, v1,
                       32'hDEAD_BEEF, 32'hA5A5_0001, 0, 0, 0));
    end
    tbl.push_back(idle_v(0, 1, 0, 32'hA5A5_0001));
    tbl.push_back(idle_v(0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle_v(1, 0, 32'hA5A5_0001, 0));
`ifdef DMEM_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle_v(1, 0, 32'hA5A5_0001, 0));
`else
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0));
    tbl.push_back(idle_v(0, 1, 0, 32'hDEAD_BEEF));
`endif
    for (int k = 0; k < 10; k++) tbl.push_back(idle_v(0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", 64'(gnt0), 0);
    chk("rst_gnt1", 64'(gnt1), 0);
    chk("rst_rvalid", 64'({rvalid0, rvalid1}), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_a", 64'(mem_a), 0);
    chk("rst_mem_d", 64'(mem_d), 0);
    chk("rst_rdata", 64'({rdata0, rdata1}), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_gnt0", i), 64'(gnt0), 64'(v.g0));
      chk($sformatf("tbl%0d_gnt1", i), 64'(gnt1), 64'(v.g1));
      chk($sformatf("tbl%0d_rvalid0", i), 64'(rvalid0), 64'(v.v0));
      chk($sformatf("tbl%0d_rvalid1", i), 64'(rvalid1), 64'(v.v1));
      chk($sformatf("tbl%0d_mem_we", i), 64'(mem_we), 64'(v.mwe));
      if (v.v0) chk($sformatf("tbl%0d_rdata0", i), 64'(rdata0), 64'(v.q0));
      if (v.v1) chk($sformatf("tbl%0d_rdata1", i), 64'(rdata1), 64'(v.q1));
      if (v.mwe) begin
        chk($sformatf("tbl%0d_mem_a", i), 64'(mem_a), 64'(v.ma));
        chk($sformatf("tbl%0d_mem_d", i), 64'(mem_d), 64'(v.md));
      end
    end
    chk("mem5_written", 64'(ram[5]), 64'(32'hDEAD_BEEF));

    // Reset arriving while a granted write is on the memory must drop it.
    drive(1, 1, 9, 32'h1234_5678, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_gnt0", 64'(gnt0), 1);
    chk("midrst_mem_we", 64'(mem_we), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outs", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we}), 0);
    chk("midrst_mem_a", 64'(mem_a), 0);
    chk("midrst_mem_d", 64'(mem_d), 0);
    chk("midrst_rdata", 64'({rdata0, rdata1}), 0);
    @(posedge clk);
    #1;
    chk("midrst_ram9", 64'(ram[9]), 64'(32'hFFFF_FFFF));
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
      model_edge_and_check();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_edge_and_check();
    model_edge_and_check();
    for (int i = 0; i < 8; i++) chk($sformatf("final_ram%0d", i), 64'(ram[i]), 64'(mmem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Grants are mutually exclusive at all times.
  always @(negedge clk) begin
    if (gnt0 && gnt1) begin
      miscompares++;
      $display("FAIL gnt_exclusive @%0t: got gnt0=%b gnt1=%b expected not both", $time, gnt0, gnt1);
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, data memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from port 0 (CPU MEM stage) / port 1 (DMA/debug).
REQ-006 SHALL have ports we0/we1  input  1  request is write (1) or read (0).
REQ-007 SHALL have ports addr0/addr1  input  AW  word address; wdata0/wdata1  input  DW  write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1  registered one-cycle grant pulse.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1 and rdata0/rdata1  output  DW  registered read return.
REQ-010 SHALL have ports mem_we  output  1, mem_a  output  AW, mem_d  output  DW, mem_q  input  DW: memory side, mem_q combinational from mem_a.

Function
REQ-011 SHALL implement FSM states IDLE (no command on memory) and ISSUE (command register driving memory).
REQ-012 SHALL treat port i as eligible at a posedge when req_i=1 and gnt_i=0; a request sampled while its gnt is high is consumed, not re-arbitrated.
REQ-013 SHALL, at a posedge with at least one eligible port, latch that port's we/addr/wdata into the command register, pulse its gnt for the following cycle, and enter/stay in ISSUE.
REQ-014 SHALL return to IDLE at a posedge with no eligible port; in IDLE mem_we=0 and mem_a/mem_d hold their last values.
REQ-015 SHALL drive mem_we/mem_a/mem_d from the command register during ISSUE; a write commits at the posedge ending that cycle.
REQ-016 SHALL, for a read, capture mem_q at the posedge ending the ISSUE cycle into rdata_i and assert rvalid_i for exactly one cycle (grant-to-data latency 1 cycle, request-to-data 2).
REQ-017 SHALL hold rdata_i stable until the next read return to port i; rvalid_i never asserts for writes.
REQ-018 SHALL sustain one access per cycle with alternating ports; a single port alone is granted at most every other cycle.
REQ-019 SHALL, when both ports are eligible, select per REQ-026/REQ-027 and leave the loser pending with no lost request.
REQ-020 SHALL never assert gnt0 and gnt1 in the same cycle.

Reset
REQ-021 SHALL asynchronously force state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_we=0, mem_a=0, mem_d=0, rdata0=rdata1=0, priority pointer=port 0.
REQ-022 SHALL, on reset during ISSUE, drop the in-flight command: no write commit after reset assertion, no rvalid.
REQ-023 SHALL not grant on the first posedge after reset deassertion unless a request is eligible then.

Configuration
REQ-024 SHALL support macro DMEM_ARB_FIXED_PRIO_EN.
REQ-025 SHALL keep the same ports and timing with or without the macro.
REQ-026 SHALL, with DMEM_ARB_FIXED_PRIO_EN defined, always grant port 0 over port 1 on conflict.
REQ-027 SHALL, without it, arbitrate round-robin: the pointer moves to the non-granted port after each grant; on conflict the pointed port wins.

Structure
REQ-028 SHALL place AW/DW defaults, the FSM state encoding (IDLE=0, ISSUE=1) and port index constants in shared package dmem_arb_pkg.
REQ-029 SHALL implement selection in sub-module rr_arb2 (2-way picker: eligible vector and pointer in, one-hot select out).
REQ-030 SHALL connect directly to the existing data memory (we/a/d/q) with no glue logic.

Verification
REQ-031 Write: port0 we0=1 addr0=5 wdata0=0xDEADBEEF for 1 cycle -> gnt0 next cycle, mem_we=1 mem_a=5 that cycle; later read of 5 returns 0xDEADBEEF.
REQ-032 Read: port1 read addr1=5 -> gnt1 at cycle+1, rvalid1=1 rdata1=0xDEADBEEF at cycle+2, rvalid0 stays 0.
REQ-033 Conflict: req0 and req1 held high 6 cycles -> round-robin grants 0,1,0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN, port 0 at every other cycle and port 1 only in between.
REQ-034 Reset mid-op: write addr=9 data=0x12345678 granted, rst asserted before the commit edge -> ram[9] unchanged (0xFFFFFFFF), all outputs 0.
REQ-035 Back-to-back: req0 write addr=1 then req1 read addr=1 on consecutive cycles -> rdata1=written value, no gap cycle.
REQ-036 Idle: no requests for 10 cycles -> mem_we=0 and no gnt or rvalid throughout.
